// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: region nibbles, MMIO register
// offsets and STATUS bit layout.
package dmem_pkg;

  localparam logic [3:0] RegionRam  = 4'h0;
  localparam logic [3:0] RegionMmio = 4'h8;

  localparam logic [27:0] OffCycle  = 28'h000_0000;
  localparam logic [27:0] OffConTx  = 28'h000_0004;
  localparam logic [27:0] OffStatus = 28'h000_0008;

  localparam int unsigned StatusEmptyBit    = 0;
  localparam int unsigned StatusFullBit     = 1;
  localparam int unsigned StatusOverflowBit = 2;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic overflow);
    logic [31:0] s;
    s                    = '0;
    s[StatusEmptyBit]    = empty;
    s[StatusFullBit]     = full;
    s[StatusOverflowBit] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/con_fifo.sv
// Circular byte FIFO for the console; full/empty come from an occupancy count.
// A pop on empty is ignored; a push when full only lands if a pop frees a slot.
module con_fifo #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  output logic [7:0]      data,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Force zero when empty so the head reads 0 out of reset without clearing storage.
  assign data    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Zero-latency data memory for the CPU MEM stage, with optional MMIO (cycle counter,
// console FIFO, status) enabled by defining DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int unsigned Aw = $clog2(MEM_WORDS);

  logic [31:0]   ram [MEM_WORDS];
  logic [Aw-1:0] ram_idx;
  logic [31:0]   ram_rdata;
  logic          ram_we;

  assign ram_idx   = daddr[2 +: Aw];
  assign ram_rdata = ram[ram_idx];

  // RAM has no reset so reads stay valid while reset is asserted.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic            ram_sel, mmio_sel;
  logic [27:0]     offs;
  logic [31:0]     cycle_q;
  logic            overflow_q, overflow_d;
  logic            fifo_push, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  logic [CntW-1:0] fifo_count;
  logic            unused_count;

  assign ram_sel      = (daddr[31:28] == RegionRam);
  assign mmio_sel     = (daddr[31:28] == RegionMmio);
  assign offs         = daddr[27:0];
  assign ram_we       = ram_sel;
  assign fifo_push    = mmio_sel && (offs == OffConTx) && dwe[0];
  assign con_valid    = !fifo_empty;
  assign con_data     = fifo_data;
  assign unused_count = ^fifo_count;

  con_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dwdata[7:0]),
    .pop       (con_ready),
    .data      (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (mmio_sel && (offs == OffStatus) && (dwe != 4'h0)) begin
      overflow_d = 1'b0;
    end
    // A full FIFO only accepts a push when the sink drains the head the same cycle.
    if (fifo_push && fifo_full && !con_ready) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 32'd1;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    drdata = '0;
    if (ram_sel) begin
      drdata = ram_rdata;
    end else if (mmio_sel) begin
      case (offs)
        OffCycle:  drdata = cycle_q;
        OffStatus: drdata = pack_status(fifo_empty, fifo_full, overflow_q);
        default:   drdata = '0;
      endcase
    end
  end
`else
  logic unused_bits;

  assign ram_we      = 1'b1;
  assign drdata      = ram_rdata;
  assign con_valid   = 1'b0;
  assign con_data    = 8'h00;
  assign unused_bits = ^{con_ready, reset, daddr[31:2+Aw], daddr[1:0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; exercises the MMIO block when DMEM_MMIO_EN is set.
module tb_dmem_responder;

  localparam int unsigned MemWords  = 64;
  localparam int unsigned FifoDepth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;
  logic        con_valid, con_ready;
  logic [7:0]  con_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [int];

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_WORDS  (MemWords),
    .FIFO_DEPTH (FifoDepth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dwe       (dwe),
    .drdata    (drdata),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready)
  );

  function automatic bit is_ram_addr(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31:28] == 4'h0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % MemWords);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] we);
    int idx;
    if (is_ram_addr(a) && we != 4'h0) begin
      idx = word_idx(a);
      ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 32'h0, d, we);
    end
  endfunction

  function automatic logic [31:0] rand_ram_addr(input int idx);
    logic [31:0] hi;
`ifdef DMEM_MMIO_EN
    hi = $urandom & 32'h0FFF_FF00;
`else
    hi = $urandom & 32'hFFFF_FF00;
`endif
    return hi | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    daddr = a; dwdata = d; dwe = we;
    @(posedge clk);
    #1;
    dwe = 4'h0;
    model_write(a, d, we);
  endtask

  task automatic read_word(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    daddr = a; dwe = 4'h0;
    #1;
    v = drdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; con_ready = 1'b0; daddr = 32'h0; dwdata = 32'h0; dwe = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (con_valid !== 1'b0 || con_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_con: got valid=%b data=%h want valid=0 data=00", con_valid, con_data);
    end
`ifdef DMEM_MMIO_EN
    read_word(32'h8000_0000, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_cycle: got %h want 00000000", v);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    read_word(32'h8000_0000, v);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL cycle_after_10: got %0d want 10", v);
    end
    read_word(32'h8000_0008, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL reset_status: got %h want 00000001", v);
    end
`else
    @(negedge clk);
    reset = 1'b0;
`endif
  endtask

  task automatic test_ram_lanes;
    logic [31:0] v;
    write_word(32'h10, 32'hDEAD_BEEF, 4'hF);
    write_word(32'h10, 32'h0000_1200, 4'h2);
    read_word(32'h10, v);
    checks++;
    if (v !== 32'hDEAD_12EF) begin
      errors++;
      $display("FAIL lane_write: got %h want DEAD12EF", v);
    end
    read_word(32'h10 + MemWords * 4, v);
    checks++;
    if (v !== 32'hDEAD_12EF) begin
      errors++;
      $display("FAIL addr_wrap: got %h want DEAD12EF", v);
    end
  endtask

  task automatic test_ram_random;
    logic [31:0] a, d, v;
    logic [3:0]  we;
    int idx;
    for (int i = 16; i < 48; i++) write_word(rand_ram_addr(i), $urandom, 4'hF);
    for (int n = 0; n < 60; n++) begin
      idx = 16 + int'($urandom_range(0, 31));
      a = rand_ram_addr(idx); d = $urandom; we = 4'($urandom);
      @(negedge clk);
      daddr = a; dwdata = d; dwe = we;
      #1;
      checks++;
      if (drdata !== ram_m[idx]) begin
        errors++;
        $display("FAIL ram_prewrite[%0d]: got %h want %h", idx, drdata, ram_m[idx]);
      end
      @(posedge clk);
      #1;
      dwe = 4'h0;
      model_write(a, d, we);
    end
    for (int i = 16; i < 48; i++) begin
      read_word(rand_ram_addr(i), v);
      checks++;
      if (v !== ram_m[i]) begin
        errors++;
        $display("FAIL ram_final[%0d]: got %h want %h", i, v, ram_m[i]);
      end
    end
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_unmapped;
    logic [31:0] addrs [4];
    logic [31:0] v;
    addrs = '{32'h4000_0000, 32'h8000_000C, 32'h8000_0004, 32'hF000_0010};
    foreach (addrs[i]) begin
      read_word(addrs[i], v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL unmapped_read[%h]: got %h want 00000000", addrs[i], v);
      end
    end
    write_word(32'h4000_0010, 32'h1234_5678, 4'hF);
    read_word(32'h10, v);
    checks++;
    if (v !== ram_m[4]) begin
      errors++;
      $display("FAIL unmapped_write: got %h want %h", v, ram_m[4]);
    end
  endtask

  task automatic test_cycle;
    logic [31:0] v1, v2;
    read_word(32'h8000_0000, v1);
    repeat (7) @(posedge clk);
    read_word(32'h8000_0000, v2);
    checks++;
    if (v2 - v1 !== 32'd7) begin
      errors++;
      $display("FAIL cycle_delta: got %0d want 7", v2 - v1);
    end
    @(negedge clk);
    daddr = 32'h8000_0000; dwdata = 32'hFFFF_0000; dwe = 4'hF;
    #1;
    v1 = drdata;
    @(posedge clk);
    #1;
    dwe = 4'h0;
    read_word(32'h8000_0000, v2);
    checks++;
    if (v2 !== v1 + 32'd1) begin
      errors++;
      $display("FAIL cycle_write_ignored: got %h want %h", v2, v1 + 32'd1);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] want);
    logic [31:0] v;
    read_word(32'h8000_0008, v);
    checks++;
    if (v !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, v, want);
    end
  endtask

  task automatic drain_expect(input string name, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      con_ready = 1'b1;
      #1;
      checks++;
      if (con_valid !== 1'b1 || con_data !== first + 8'(i)) begin
        errors++;
        $display("FAIL %s[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 name, i, con_valid, con_data, first + 8'(i));
      end
    end
    @(negedge clk);
    con_ready = 1'b0;
    #1;
    checks++;
    if (con_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: got valid=%b want 0", name, con_valid);
    end
  endtask

  task automatic test_fifo_overflow;
    con_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(32'h8000_0004, 32'h41 + i, 4'h1);
    check_status("ovf_status", 32'h6);
    drain_expect("ovf_drain", 8'h41, 4);
    check_status("ovf_sticky", 32'h5);
    write_word(32'h8000_0008, 32'h0, 4'h4);
    check_status("ovf_clear", 32'h1);
  endtask

  task automatic test_full_push_pop;
    con_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(32'h8000_0004, 32'h50 + i, 4'h1);
    check_status("full_status", 32'h2);
    @(negedge clk);
    daddr = 32'h8000_0004; dwdata = 32'h54; dwe = 4'h1; con_ready = 1'b1;
    @(posedge clk);
    #1;
    dwe = 4'h0; con_ready = 1'b0;
    check_status("full_pushpop_status", 32'h2);
    drain_expect("full_pushpop_drain", 8'h51, 4);
  endtask

  task automatic test_empty_push_pop;
    @(negedge clk);
    daddr = 32'h8000_0004; dwdata = 32'h77; dwe = 4'h1; con_ready = 1'b1;
    #1;
    checks++;
    if (con_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop_before: got valid=%b want 0", con_valid);
    end
    @(posedge clk);
    #1;
    dwe = 4'h0;
    checks++;
    if (con_valid !== 1'b1 || con_data !== 8'h77) begin
      errors++;
      $display("FAIL empty_pushpop_after: got valid=%b data=%h want valid=1 data=77",
               con_valid, con_data);
    end
    @(posedge clk);
    #1;
    con_ready = 1'b0;
    checks++;
    if (con_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop_drained: got valid=%b want 0", con_valid);
    end
  endtask

  task automatic test_fifo_random;
    logic [7:0]  q [$];
    logic        ovf;
    logic [7:0]  b;
    logic [31:0] want;
    int          op;
    bit          rdy, pop_ok;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ovf = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      op = int'($urandom_range(0, 4));
      rdy = 1'($urandom);
      b = 8'($urandom);
      con_ready = rdy;
      dwe = 4'h0;
      case (op)
        0, 1: begin daddr = 32'h8000_0004; dwdata = {24'h0, b}; dwe = 4'h1; end
        2: daddr = 32'h8000_0008;
        3: if (b < 8'h20) begin daddr = 32'h8000_0008; dwdata = 32'h0; dwe = 4'h8; end
           else daddr = 32'h8000_000C;
        default: daddr = 32'h0000_0040;
      endcase
      #1;
      checks++;
      if (con_valid !== (q.size() != 0) || (q.size() != 0 && con_data !== q[0])) begin
        errors++;
        $display("FAIL rand_head[%0d]: got valid=%b data=%h want valid=%b data=%h", n,
                 con_valid, con_data, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00);
      end
      if (op == 2) begin
        want = {29'h0, ovf, q.size() == FifoDepth, q.size() == 0};
        checks++;
        if (drdata !== want) begin
          errors++;
          $display("FAIL rand_status[%0d]: got %h want %h", n, drdata, want);
        end
      end
      @(posedge clk);
      pop_ok = rdy && q.size() != 0;
      if (pop_ok) void'(q.pop_front());
      if (op == 0 || op == 1) begin
        if (q.size() < FifoDepth) q.push_back(b);
        else ovf = 1'b1;
      end
      if (op == 3 && b < 8'h20) ovf = 1'b0;
    end
    #1;
    dwe = 4'h0;
    con_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    con_ready = 1'b0;
    write_word(32'h8000_0004, 32'hA1, 4'h1);
    write_word(32'h8000_0004, 32'hA2, 4'h1);
    @(negedge clk);
    daddr = 32'h10;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (con_valid !== 1'b0 || con_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_con: got valid=%b data=%h want valid=0 data=00",
               con_valid, con_data);
    end
    checks++;
    if (drdata !== ram_m[4]) begin
      errors++;
      $display("FAIL mid_reset_ram: got %h want %h", drdata, ram_m[4]);
    end
    check_status("mid_reset_status", 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (con_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_con: got valid=%b want 0", con_valid);
    end
  endtask
`else
  task automatic test_no_mmio;
    logic [31:0] v;
    con_ready = 1'b1;
    write_word(32'h8000_0000, 32'h55, 4'hF);
    read_word(32'h0, v);
    checks++;
    if (v !== 32'h55) begin
      errors++;
      $display("FAIL no_mmio_alias: got %h want 00000055", v);
    end
    for (int i = 0; i < 4; i++) begin
      write_word(32'h8000_0004, 32'h41 + i, 4'h1);
      checks++;
      if (con_valid !== 1'b0 || con_data !== 8'h00) begin
        errors++;
        $display("FAIL no_mmio_con[%0d]: got valid=%b data=%h want valid=0 data=00",
                 i, con_valid, con_data);
      end
    end
    read_word(32'h0, v);
    checks++;
    if (v !== ram_m[0]) begin
      errors++;
      $display("FAIL no_mmio_contx_alias: got %h want %h", v, ram_m[0]);
    end
    con_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ram_lanes();
    test_ram_random();
`ifdef DMEM_MMIO_EN
    test_unmapped();
    test_cycle();
    test_fifo_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_fifo_random();
    test_reset_mid();
`else
    test_no_mmio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, number of 32-bit RAM words (power of two).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, console FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port daddr  input  32  byte address from the CPU data port.
REQ-006 The block SHALL have port dwdata  input  32  store data, lane-aligned.
REQ-007 The block SHALL have port dwe  input  4  per-byte write enable; 0 means read.
REQ-008 The block SHALL have port drdata  output  32  read data for daddr.
REQ-009 The block SHALL have port con_valid  output  1  console byte available.
REQ-010 The block SHALL have port con_data  output  8  console byte at FIFO head.
REQ-011 The block SHALL have port con_ready  input  1  console sink accepts the byte.

Function
REQ-012 The block SHALL decode daddr[31:28]==0x0 as RAM, with word index daddr[2+:log2(MEM_WORDS)] (higher bits ignored, so addresses wrap), and daddr[31:28]==0x8 as MMIO; all other addresses are unmapped.
REQ-013 drdata SHALL be combinational from daddr in the same cycle (zero latency), because the CPU samples it in its MEM stage.
REQ-014 RAM writes SHALL update only lanes with dwe[i]=1, at posedge; a same-cycle read returns pre-write data.
REQ-015 MMIO 0x8000_0000 CYCLE SHALL read a 32-bit free-running counter, +1 per cycle, wrapping 0xFFFF_FFFF->0; writes are ignored.
REQ-016 MMIO 0x8000_0004 CON_TX SHALL push dwdata[7:0] when dwe[0]=1; it reads 0.
REQ-017 MMIO 0x8000_0008 STATUS SHALL read {29'b0, overflow, full, empty}; any write with dwe!=0 clears overflow.
REQ-018 con_valid SHALL equal !empty and con_data SHALL equal the FIFO head; a pop occurs at posedge when con_valid&&con_ready.
REQ-019 A push when full without a same-cycle pop SHALL be dropped and set overflow (sticky); a push and pop in the same cycle when full SHALL both succeed.
REQ-020 A push and pop in the same cycle when empty SHALL only push; con_valid asserts the next cycle.
REQ-021 Unmapped or unused MMIO reads SHALL return 0; writes to them SHALL be ignored.
REQ-022 The FIFO SHALL be circular, with pointers wrapping modulo FIFO_DEPTH; full/empty SHALL derive from an occupancy count 0..FIFO_DEPTH.

Reset
REQ-023 On reset: CYCLE=0, FIFO empty, overflow=0, con_valid=0, con_data=0; RAM contents are not reset.
REQ-024 Reset mid-operation SHALL discard FIFO contents immediately (asynchronously); drdata for RAM remains valid during reset.

Configuration
REQ-025 With macro DMEM_MMIO_EN defined, REQ-015..REQ-022 apply.
REQ-026 Without DMEM_MMIO_EN, the entire address space SHALL map to RAM (wrapping), con_valid and con_data SHALL be tied 0, con_ready SHALL be ignored, and no counter or FIFO SHALL be synthesized.

Structure
REQ-027 Shared package dmem_pkg SHALL hold region nibbles (RAM 0x0, MMIO 0x8), register offsets (CYCLE 0x0, CON_TX 0x4, STATUS 0x8) and STATUS bit positions (empty 0, full 1, overflow 2).
REQ-028 The console FIFO SHALL be a sub-module named con_fifo (push/pop/data/full/empty/count).

Verification
REQ-029 Write 0xDEADBEEF to 0x10 with dwe=0xF, then dwe=0x2 with data 0x0000_1200 -> reading 0x10 returns 0xDEAD12EF.
REQ-030 Read 0x10 + MEM_WORDS*4 -> returns the same word as 0x10 (wrap).
REQ-031 Hold reset for 3 cycles, release, then read CYCLE after 10 posedges -> returns 10 (+/-0 per the sampling edge chosen by the bench).
REQ-032 With con_ready=0, push 0x41..0x45 (5 bytes, depth 4) -> STATUS=0b110, and drain yields 0x41,0x42,0x43,0x44.
REQ-033 When full, push and pop in the same cycle -> no overflow, count stays 4, and the new byte appears last.
REQ-034 Build without DMEM_MMIO_EN, write 0x8000_0000 with 0x55 -> reading 0x0 returns 0x55, and con_valid stays 0.
